lcd_spi_rx: RTL and testbench
=============================

Name: lcd_spi_rx

Overview:
- Display-side receiver for the 4-wire SPI LCD link (CS, RS/DC, serial clock, MOSI); the panel-controller end of the link driven by our LCD writer.
- Deserialises bytes MSB-first and decodes the ST7789 command subset we use: SLPOUT/SLPIN, DISPON/DISPOFF, MADCTL, COLMOD, CASET, RASET, RAMWR, SWRESET.
- Emits addressed RGB565 pixel writes.
- Used as a synthesizable loopback checker and on-board link monitor.

Parameters:
- XE_RST, 16'd239, column-end value after reset/SWRESET.
- YE_RST, 16'd319, row-end value after reset/SWRESET.

Ports:
- clk  in  1  serial clock; connect to lcd_clk; data sampled on rising edge.
- resetn  in  1  asynchronous active-low reset.
- lcd_cs  in  1  chip select, active low.
- lcd_rs  in  1  0 = command byte, 1 = data byte; sampled with the first bit of each byte.
- lcd_data  in  1  MOSI, MSB first.
- lcd_resetn  in  1  panel reset, active low; synchronous clear, same effect as SWRESET.
- rx_valid  out  1  one-cycle pulse: byte complete.
- rx_is_data  out  1  RS value latched for rx_byte.
- rx_byte  out  8  received byte.
- pix_valid  out  1  one-cycle pulse: pixel written.
- pix_x  out  16  column of the written pixel.
- pix_y  out  16  row of the written pixel.
- pix_data  out  16  RGB565 value, first byte is [15:8].
- frame_done  out  1  one-cycle pulse, coincident with pix_valid, on the last pixel of the window.
- sleep_out  out  1  1 after SLPOUT.
- disp_on  out  1  1 after DISPON.
- madctl  out  8  last MADCTL parameter.
- colmod  out  8  last COLMOD parameter.
- abort  out  1  one-cycle pulse: CS rose with 1-7 bits pending.

Behaviour:
- Reset values: all outputs 0; xs = ys = 0; xe = XE_RST; ye = YE_RST; state IDLE; bit_cnt = 0.
- Deserialiser, on each rising clk edge with lcd_cs = 0:
  - shift lcd_data into sreg;
  - on bit 0, latch lcd_rs into dc_r;
  - bit_cnt counts 0..7 and wraps, so back-to-back bytes under one CS-low window are legal (pixel bursts keep CS low for 16 bits).
- Byte output: on the edge sampling bit 7, rx_byte = {sreg[6:0], lcd_data}, rx_is_data = dc_r, rx_valid = 1 for one cycle. Latency is therefore 0 extra cycles after the last bit.
- CS deassert (lcd_cs = 1 at an edge): bit_cnt <= 0 and the partial byte is discarded. If bit_cnt was nonzero, pulse abort. Decoder state is not affected.
- Decoder states: IDLE, PARAM (collecting parameters for the current command, param_idx 0..3), RAMWR_HI, RAMWR_LO.
- A command byte (rs = 0) always terminates the current state and starts the new command, including mid-parameter and mid-pixel:
  - an incomplete CASET/RASET commits nothing;
  - a dangling RAMWR high byte is dropped.
- Per-command behaviour:
  - 0x11 sets sleep_out; 0x10 clears it.
  - 0x29 sets disp_on; 0x28 clears it.
  - 0x01 SWRESET restores reset values of sleep_out, disp_on, madctl, colmod, xs, xe, ys, ye.
  - 0x36: parameter 0 loads madctl. 0x3A: parameter 0 loads colmod. Further parameters are ignored.
  - 0x2A CASET: parameters 0..3 stage {xs_hi, xs_lo, xe_hi, xe_lo}; xs/xe commit together on parameter 3. Parameters beyond 3 are ignored.
  - 0x2B RASET: same scheme for ys/ye.
  - 0x2C RAMWR: cur_x <= xs, cur_y <= ys; go to RAMWR_HI.
  - Any other command: go to PARAM and ignore its data bytes.
- RAMWR_HI: a data byte is held as pix_hi; go to RAMWR_LO.
- RAMWR_LO: a data byte causes, in the same edge:
  - pix_valid = 1, pix_data = {pix_hi, byte}, pix_x = cur_x, pix_y = cur_y;
  - advance the address:
    - if cur_x >= xe: cur_x <= xs and the row advances;
    - otherwise cur_x <= cur_x + 1.
  - row advance:
    - if cur_y >= ye: cur_y <= ys and frame_done = 1;
    - otherwise cur_y <= cur_y + 1.
  - return to RAMWR_HI.
- Comparisons use >=, so a window with start > end yields one pixel per row/column and never runs away.
- Data bytes received in IDLE are ignored.
- lcd_resetn = 0 at an edge: same effect as SWRESET, plus bit_cnt <= 0 and state IDLE.
- Asynchronous resetn mid-byte or mid-frame: everything returns to reset values immediately.

Decomposition:
- Package lcd_pkg holds:
  - command opcode constants (CMD_SLPOUT 8'h11, CMD_SLPIN 8'h10, CMD_DISPON 8'h29, CMD_DISPOFF 8'h28, CMD_SWRESET 8'h01, CMD_MADCTL 8'h36, CMD_COLMOD 8'h3A, CMD_CASET 8'h2A, CMD_RASET 8'h2B, CMD_RAMWR 8'h2C);
  - decoder state encodings.
- Sub-module lcd_spi_deser (shift register, bit counter, CS abort) feeds the decoder in lcd_spi_rx.

Test Plan:
- Send 0x11 as a command (rs = 0, 8 bits, CS high afterwards) -> rx_valid pulse with rx_byte = 8'h11, rx_is_data = 0; sleep_out = 1.
- Send 36/70, 3A/05, 29 -> madctl = 8'h70, colmod = 8'h05, disp_on = 1.
- Send CASET 00 28 01 17, RASET 00 35 00 BB, RAMWR, then 32400 pixels (0x001F for indices < 10800, 0x07E0 for < 21600, 0xF800 otherwise), 16 bits per CS window:
  - pixel 0 at (40,53) with data 0x001F;
  - pixel 10800 at (40,98) with data 0x07E0;
  - pixel 32399 at (279,187) with frame_done = 1;
  - pix_valid count = 32400.
- CS raised after 5 bits of a byte -> abort pulse, no rx_valid; the next full byte decodes correctly.
- CASET 00 10 followed by command 0x2C -> xs/xe unchanged (0/239); first pixel at (0, ys).
- SWRESET, or lcd_resetn low for one cycle, after setup -> madctl = 0, colmod = 0, sleep_out = 0, disp_on = 0, xe = 239, ye = 319.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - ST7789 opcode subset and decoder state encoding for the LCD SPI receiver
package lcd_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPIN   = 8'h10;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  // Parameter index saturates here so trailing parameters are ignored.
  localparam logic [2:0] PARAM_IDX_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PARAM    = 2'd1,
    ST_RAMWR_HI = 2'd2,
    ST_RAMWR_LO = 2'd3
  } dec_state_t;

endpackage

// File: rtl/lcd_spi_rx_if.sv
// rtl/lcd_spi_rx_if.sv - 4-wire SPI LCD link: chip select, register select, MOSI and panel reset
interface lcd_spi_rx_if;

  logic lcd_cs;
  logic lcd_rs;
  logic lcd_data;
  logic lcd_resetn;

  modport master (
    output lcd_cs,
    output lcd_rs,
    output lcd_data,
    output lcd_resetn
  );

  modport slave (
    input lcd_cs,
    input lcd_rs,
    input lcd_data,
    input lcd_resetn
  );

endinterface

// File: rtl/lcd_spi_deser.sv
// rtl/lcd_spi_deser.sv - MSB-first byte deserialiser with CS-abort detection
module lcd_spi_deser (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcd_cs,
  input  logic       lcd_rs,
  input  logic       lcd_data,
  input  logic       lcd_resetn,
  output logic       byte_done,
  output logic [7:0] byte_val,
  output logic       byte_is_data,
  output logic       rx_valid,
  output logic       rx_is_data,
  output logic [7:0] rx_byte,
  output logic       abort
);

  logic [6:0] sreg;
  logic [2:0] bit_cnt;
  logic       dc_r;

  // Combinational view of the byte completing on this edge, so the decoder acts in the same cycle.
  assign byte_done    = ~lcd_cs & lcd_resetn & (bit_cnt == 3'd7);
  assign byte_val     = {sreg, lcd_data};
  assign byte_is_data = dc_r;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg       <= '0;
      bit_cnt    <= '0;
      dc_r       <= 1'b0;
      rx_valid   <= 1'b0;
      rx_is_data <= 1'b0;
      rx_byte    <= '0;
      abort      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      abort    <= 1'b0;
      if (!lcd_resetn) begin
        bit_cnt <= '0;
      end else if (lcd_cs) begin
        abort   <= (bit_cnt != 3'd0);
        bit_cnt <= '0;
      end else begin
        sreg    <= {sreg[5:0], lcd_data};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd0) begin
          dc_r <= lcd_rs;
        end
        if (byte_done) begin
          rx_valid   <= 1'b1;
          rx_is_data <= dc_r;
          rx_byte    <= byte_val;
        end
      end
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// rtl/lcd_spi_rx.sv - LCD-side SPI receiver: ST7789 command decode and addressed RGB565 pixel writes
module lcd_spi_rx
  import lcd_pkg::*;
#(
  parameter logic [15:0] XE_RST = 16'd239,
  parameter logic [15:0] YE_RST = 16'd319
) (
  input  logic         clk,
  input  logic         resetn,
  lcd_spi_rx_if.slave  lcd,
  output logic         rx_valid,
  output logic         rx_is_data,
  output logic [7:0]   rx_byte,
  output logic         pix_valid,
  output logic [15:0]  pix_x,
  output logic [15:0]  pix_y,
  output logic [15:0]  pix_data,
  output logic         frame_done,
  output logic         sleep_out,
  output logic         disp_on,
  output logic [7:0]   madctl,
  output logic [7:0]   colmod,
  output logic         abort
);

  logic       byte_done;
  logic [7:0] byte_val;
  logic       byte_is_data;

  lcd_spi_deser u_deser (
    .clk          (clk),
    .resetn       (resetn),
    .lcd_cs       (lcd.lcd_cs),
    .lcd_rs       (lcd.lcd_rs),
    .lcd_data     (lcd.lcd_data),
    .lcd_resetn   (lcd.lcd_resetn),
    .byte_done    (byte_done),
    .byte_val     (byte_val),
    .byte_is_data (byte_is_data),
    .rx_valid     (rx_valid),
    .rx_is_data   (rx_is_data),
    .rx_byte      (rx_byte),
    .abort        (abort)
  );

  dec_state_t  state, state_nxt;
  logic [7:0]  cmd;
  logic [2:0]  param_idx;
  logic [23:0] stage;
  logic [15:0] xs, xe, ys, ye;
  logic [15:0] cur_x, cur_y;
  logic [7:0]  pix_hi;

  logic cfg_clear;
  logic cmd_fire;
  logic param_fire;
  logic hi_fire;
  logic pix_fire;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Any command byte preempts whatever is in progress.
  always_comb begin
    state_nxt  = state;
    cfg_clear  = 1'b0;
    cmd_fire   = 1'b0;
    param_fire = 1'b0;
    hi_fire    = 1'b0;
    pix_fire   = 1'b0;
    if (!lcd.lcd_resetn) begin
      state_nxt = ST_IDLE;
      cfg_clear = 1'b1;
    end else if (byte_done) begin
      if (!byte_is_data) begin
        cmd_fire  = 1'b1;
        cfg_clear = (byte_val == CMD_SWRESET);
        state_nxt = (byte_val == CMD_RAMWR) ? ST_RAMWR_HI : ST_PARAM;
      end else begin
        case (state)
          ST_PARAM: param_fire = 1'b1;
          ST_RAMWR_HI: begin
            hi_fire   = 1'b1;
            state_nxt = ST_RAMWR_LO;
          end
          ST_RAMWR_LO: begin
            pix_fire  = 1'b1;
            state_nxt = ST_RAMWR_HI;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd        <= '0;
      param_idx  <= '0;
      stage      <= '0;
      xs         <= '0;
      xe         <= XE_RST;
      ys         <= '0;
      ye         <= YE_RST;
      cur_x      <= '0;
      cur_y      <= '0;
      pix_hi     <= '0;
      sleep_out  <= 1'b0;
      disp_on    <= 1'b0;
      madctl     <= '0;
      colmod     <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;

      if (cfg_clear) begin
        sleep_out <= 1'b0;
        disp_on   <= 1'b0;
        madctl    <= '0;
        colmod    <= '0;
        xs        <= '0;
        xe        <= XE_RST;
        ys        <= '0;
        ye        <= YE_RST;
      end

      if (cmd_fire) begin
        cmd       <= byte_val;
        param_idx <= '0;
        case (byte_val)
          CMD_SLPOUT:  sleep_out <= 1'b1;
          CMD_SLPIN:   sleep_out <= 1'b0;
          CMD_DISPON:  disp_on   <= 1'b1;
          CMD_DISPOFF: disp_on   <= 1'b0;
          CMD_RAMWR: begin
            cur_x <= xs;
            cur_y <= ys;
          end
          default: ;
        endcase
      end

      // Window bounds only change once all four bytes have arrived.
      if (param_fire) begin
        if (param_idx != PARAM_IDX_MAX) begin
          param_idx <= param_idx + 3'd1;
        end
        case (cmd)
          CMD_MADCTL: if (param_idx == 3'd0) madctl <= byte_val;
          CMD_COLMOD: if (param_idx == 3'd0) colmod <= byte_val;
          CMD_CASET, CMD_RASET: begin
            case (param_idx)
              3'd0: stage[23:16] <= byte_val;
              3'd1: stage[15:8]  <= byte_val;
              3'd2: stage[7:0]   <= byte_val;
              3'd3: begin
                if (cmd == CMD_CASET) begin
                  xs <= stage[23:8];
                  xe <= {stage[7:0], byte_val};
                end else begin
                  ys <= stage[23:8];
                  ye <= {stage[7:0], byte_val};
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end

      if (hi_fire) begin
        pix_hi <= byte_val;
      end

      // >= keeps inverted windows bounded to one step per axis.
      if (pix_fire) begin
        pix_valid <= 1'b1;
        pix_x     <= cur_x;
        pix_y     <= cur_y;
        pix_data  <= {pix_hi, byte_val};
        if (cur_x >= xe) begin
          cur_x <= xs;
          if (cur_y >= ye) begin
            cur_y      <= ys;
            frame_done <= 1'b1;
          end else begin
            cur_y <= cur_y + 16'd1;
          end
        end else begin
          cur_x <= cur_x + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb/tb_lcd_spi_rx.sv - randomized self-checking bench for lcd_spi_rx against a window-index model
module tb_lcd_spi_rx;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rx_valid, rx_is_data, pix_valid, frame_done, sleep_out, disp_on, abort;
  logic [7:0]  rx_byte, madctl, colmod;
  logic [15:0] pix_x, pix_y, pix_data;

  lcd_spi_rx_if lcd ();

  lcd_spi_rx dut (
    .clk        (clk),
    .resetn     (resetn),
    .lcd        (lcd),
    .rx_valid   (rx_valid),
    .rx_is_data (rx_is_data),
    .rx_byte    (rx_byte),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .frame_done (frame_done),
    .sleep_out  (sleep_out),
    .disp_on    (disp_on),
    .madctl     (madctl),
    .colmod     (colmod),
    .abort      (abort)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] d; bit fd; } pix_t;
  typedef struct { bit rs; logic [7:0] b; } rx_t;

  pix_t pix_q[$];
  rx_t  rx_q[$];
  pix_t pix_e;
  rx_t  rx_e;

  int n_tests = 0;
  int n_fail = 0;
  int n_abort_exp = 0;
  int n_abort_got = 0;
  int n_pix_exp = 0;
  int n_pix_got = 0;

  bit         m_sleep, m_disp, m_ram, m_hi_ok;
  logic [7:0] m_mad, m_col, m_cmd, m_hi;
  int         m_xs, m_xe, m_ys, m_ye, m_k;
  logic [7:0] m_par[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cfg_reset();
    m_sleep = 1'b0; m_disp = 1'b0; m_mad = 8'h00; m_col = 8'h00;
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
  endtask

  task automatic model_full_reset();
    model_cfg_reset();
    m_cmd = 8'h00; m_ram = 1'b0; m_hi_ok = 1'b0; m_k = 0;
    m_par.delete();
  endtask

  // Pixel k of a RAMWR lands at (k mod w, (k / w) mod h) inside the window.
  task automatic model_byte(input bit rs, input logic [7:0] b);
    rx_t r;
    pix_t p;
    int w, h, k;
    r.rs = rs; r.b = b;
    rx_q.push_back(r);
    if (!rs) begin
      m_cmd = b; m_par.delete(); m_ram = (b == CMD_RAMWR); m_hi_ok = 1'b0; m_k = 0;
      case (b)
        CMD_SLPOUT:  m_sleep = 1'b1;
        CMD_SLPIN:   m_sleep = 1'b0;
        CMD_DISPON:  m_disp = 1'b1;
        CMD_DISPOFF: m_disp = 1'b0;
        CMD_SWRESET: model_cfg_reset();
        default: ;
      endcase
    end else if (m_ram) begin
      if (!m_hi_ok) begin
        m_hi = b; m_hi_ok = 1'b1;
      end else begin
        w = (m_xe >= m_xs) ? m_xe - m_xs + 1 : 1;
        h = (m_ye >= m_ys) ? m_ye - m_ys + 1 : 1;
        k = m_k % (w * h);
        p.x = 16'(m_xs + k % w);
        p.y = 16'(m_ys + k / w);
        p.d = {m_hi, b};
        p.fd = (k == w * h - 1);
        pix_q.push_back(p);
        m_k++; n_pix_exp++; m_hi_ok = 1'b0;
      end
    end else begin
      m_par.push_back(b);
      if (m_cmd == CMD_MADCTL && m_par.size() == 1) m_mad = b;
      if (m_cmd == CMD_COLMOD && m_par.size() == 1) m_col = b;
      if (m_cmd == CMD_CASET && m_par.size() == 4) begin
        m_xs = int'({m_par[0], m_par[1]}); m_xe = int'({m_par[2], m_par[3]});
      end
      if (m_cmd == CMD_RASET && m_par.size() == 4) begin
        m_ys = int'({m_par[0], m_par[1]}); m_ye = int'({m_par[2], m_par[3]});
      end
    end
  endtask

  task automatic send_bits(input bit rs, input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      lcd.lcd_cs = 1'b0; lcd.lcd_rs = rs; lcd.lcd_data = b[7-i];
    end
    if (nbits == 8) model_byte(rs, b);
  endtask

  task automatic cs_high();
    @(negedge clk);
    lcd.lcd_cs = 1'b1;
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    send_bits(rs, b, 8);
    cs_high();
  endtask

  task automatic send_pixel(input logic [15:0] d, input bit burst);
    send_bits(1'b1, d[15:8], 8);
    send_bits(1'b1, d[7:0], 8);
    if (!burst) cs_high();
  endtask

  task automatic check_status();
    check("sleep_out", 32'(sleep_out), 32'(m_sleep));
    check("disp_on", 32'(disp_on), 32'(m_disp));
    check("madctl", 32'(madctl), 32'(m_mad));
    check("colmod", 32'(colmod), 32'(m_col));
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) check("rx_unexpected", 32'(rx_valid), 32'd0);
        else begin
          rx_e = rx_q.pop_front();
          check("rx_byte", 32'(rx_byte), 32'(rx_e.b));
          check("rx_is_data", 32'(rx_is_data), 32'(rx_e.rs));
        end
      end
      if (pix_valid) begin
        n_pix_got++;
        if (pix_q.size() == 0) check("pix_unexpected", 32'(pix_valid), 32'd0);
        else begin
          pix_e = pix_q.pop_front();
          check("pix_x", 32'(pix_x), 32'(pix_e.x));
          check("pix_y", 32'(pix_y), 32'(pix_e.y));
          check("pix_data", 32'(pix_data), 32'(pix_e.d));
          check("frame_done", 32'(frame_done), 32'(pix_e.fd));
        end
      end
      if (frame_done && !pix_valid) check("frame_done_lone", 32'(frame_done), 32'd0);
      if (abort) begin
        n_abort_got++;
        check("abort_with_rx", 32'(rx_valid), 32'd0);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, n;
    bit burst;
    logic [7:0] pv[5];
    logic [7:0] c;
    logic [15:0] d;

    lcd.lcd_cs = 1'b1; lcd.lcd_rs = 1'b0; lcd.lcd_data = 1'b0; lcd.lcd_resetn = 1'b1;
    model_full_reset();
    repeat (3) @(negedge clk);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_xy", 32'({pix_x, pix_y}), 32'd0);
    check("rst_status", 32'({sleep_out, disp_on, madctl, colmod, abort, frame_done}), 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    send_byte(1'b0, CMD_SLPOUT);
    check("slpout", 32'(sleep_out), 32'd1);
    send_byte(1'b0, CMD_MADCTL); send_byte(1'b1, 8'h70);
    send_byte(1'b0, CMD_COLMOD); send_byte(1'b1, 8'h05);
    send_byte(1'b0, CMD_DISPON);
    check("madctl_70", 32'(madctl), 32'h70);
    check("colmod_05", 32'(colmod), 32'h05);
    check_status();

    // Scaled frame: 8 x 4 window at (40,53).
    send_byte(1'b0, CMD_CASET);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h28); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h2F);
    send_byte(1'b0, CMD_RASET);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h35); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h38);
    send_byte(1'b0, CMD_RAMWR);
    for (int i = 0; i < 32; i++) begin
      d = (i < 11) ? 16'h001F : (i < 22) ? 16'h07E0 : 16'hF800;
      send_pixel(d, 1'b0);
      if (i == 0) check("px0_xy", 32'({pix_x, pix_y}), {16'd40, 16'd53});
      if (i == 11) check("px11_data", 32'(pix_data), 32'h07E0);
      if (i == 31) check("px31_xy_fd", 32'({pix_x[14:0], pix_y, frame_done}), {15'd47, 16'd56, 1'b1});
    end

    send_bits(1'b1, 8'hA5, 5);
    cs_high();
    n_abort_exp++;
    send_byte(1'b0, CMD_DISPOFF);
    check("after_abort_disp", 32'(disp_on), 32'd0);

    send_byte(1'b0, CMD_SWRESET);
    check("swreset_cfg", 32'({sleep_out, disp_on, madctl, colmod}), 32'd0);
    send_byte(1'b0, CMD_RASET);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h07); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h09);
    send_byte(1'b0, CMD_CASET); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h10);
    send_byte(1'b0, CMD_RAMWR);
    send_pixel(16'h1234, 1'b0);
    check("partial_caset_xy", 32'({pix_x, pix_y}), {16'd0, 16'd7});

    send_byte(1'b0, CMD_SLPOUT);
    send_byte(1'b0, CMD_MADCTL); send_byte(1'b1, 8'hC0);
    @(negedge clk); lcd.lcd_resetn = 1'b0;
    @(negedge clk); lcd.lcd_resetn = 1'b1;
    model_full_reset();
    check("lcd_resetn_cfg", 32'({sleep_out, disp_on, madctl, colmod}), 32'd0);
    check_status();

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: begin
          n = $urandom_range(0, 3);
          c = (n == 0) ? CMD_SLPOUT : (n == 1) ? CMD_SLPIN : (n == 2) ? CMD_DISPON : CMD_DISPOFF;
          send_byte(1'b0, c);
        end
        1: begin
          send_byte(1'b0, ($urandom_range(0, 1) != 0) ? CMD_MADCTL : CMD_COLMOD);
          n = $urandom_range(0, 2);
          repeat (n) send_byte(1'b1, 8'($urandom));
        end
        2, 3: begin
          pv[0] = 8'h00; pv[1] = 8'($urandom_range(0, 12));
          pv[2] = 8'h00; pv[3] = 8'($urandom_range(0, 12));
          pv[4] = 8'($urandom);
          send_byte(1'b0, (op == 2) ? CMD_CASET : CMD_RASET);
          n = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 5) : 4;
          for (int j = 0; j < n; j++) send_byte(1'b1, pv[j]);
        end
        4, 5: begin
          send_byte(1'b0, CMD_RAMWR);
          n = $urandom_range(0, 24);
          burst = ($urandom_range(0, 1) != 0);
          for (int j = 0; j < n; j++) send_pixel(16'($urandom), burst);
          if ($urandom_range(0, 3) == 0) send_bits(1'b1, 8'($urandom), 8);
          cs_high();
        end
        6: begin
          send_bits(1'($urandom), 8'($urandom), $urandom_range(1, 7));
          cs_high();
          n_abort_exp++;
        end
        default: begin
          send_byte(1'b0, ($urandom_range(0, 1) != 0) ? 8'h00 : 8'hB2);
          send_byte(1'b1, 8'($urandom));
        end
      endcase
      check_status();
    end

    send_bits(1'b0, CMD_DISPON, 4);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_out", 32'({rx_valid, pix_valid, frame_done, sleep_out, disp_on, abort, madctl, colmod}), 32'd0);
    check("async_rst_pix", 32'({pix_x, pix_data}), 32'd0);
    model_full_reset();
    @(negedge clk); lcd.lcd_cs = 1'b1;
    @(negedge clk); resetn = 1'b1;
    send_byte(1'b0, CMD_DISPON);
    check_status();

    repeat (5) @(negedge clk);
    check("pix_count", n_pix_got, n_pix_exp);
    check("abort_count", n_abort_got, n_abort_exp);
    check("rx_q_empty", rx_q.size(), 0);
    check("pix_q_empty", pix_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
